// File: rtl/ring_phase_monitor.sv
// ring_phase_monitor: watches a one-hot ring counter phase vector. It checks
// that every sample is one-hot and is a right-rotation of the previous one.
// It reports the binary phase index, lock status, revolution pulses/count and
// a saturating error count.
// Optional build macro RING_PHASE_MON_SNAP_EN adds the last_bad output. That
// port holds the first bad sample seen since reset or clr.
module ring_phase_monitor #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8,
  parameter int REV_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             phase_vld,
  input  logic [N-1:0]     phase_in,
  output logic [IDX_W-1:0] idx,
  output logic             idx_vld,
  output logic             locked,
  output logic             fault,
  output logic [ERR_W-1:0] err_cnt,
  output logic             wrap_pulse,
  output logic [REV_W-1:0] rev_cnt
`ifdef RING_PHASE_MON_SNAP_EN
  ,
  output logic [N-1:0]     last_bad
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    LOCK  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       good_q, good_d;
  logic [N-1:0]     prev_q;
  logic [IDX_W-1:0] idx_q;
  logic             idx_vld_q;
  logic             fault_q;
  logic [ERR_W-1:0] err_q;
  logic             wrap_q;
  logic [REV_W-1:0] rev_q;

  logic             onehot;
  logic [N-1:0]     exp_vec;
  logic             match;
  logic [IDX_W-1:0] pos;
  logic             accept;
  logic             bad;
  logic             wrap_d;
  logic             fault_set;

  // Classify the incoming sample: one-hot test, expected rotation, bit position
  always_comb begin
    onehot  = (phase_in != '0) &&
              ((phase_in & (phase_in - {{(N-1){1'b0}}, 1'b1})) == '0);
    exp_vec = {prev_q[0], prev_q[N-1:1]};
    match   = onehot && (phase_in == exp_vec);
    pos     = '0;
    for (int i = 0; i < N; i++) begin
      if (phase_in[i]) begin
        pos = IDX_W'(i);
      end
    end
  end

  // State register; clr returns the FSM to IDLE just like reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else if (clr) begin
      state_q <= IDLE;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
    end
  end

  // Next-state logic: acquire LOCK_CNT good rotations, then hold lock
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    if (phase_vld) begin
      case (state_q)
        IDLE, FAULT: begin
          if (onehot) begin
            state_d = ACQ;
            good_d  = '0;
          end
        end
        ACQ: begin
          if (match) begin
            good_d = good_q + 4'd1;
            if (good_q + 4'd1 == 4'(LOCK_CNT)) begin
              state_d = LOCK;
            end
          end else if (onehot) begin
            good_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
        LOCK: begin
          if (!match) begin
            state_d = FAULT;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode: which events this sample produces
  always_comb begin
    accept    = phase_vld && onehot;
    bad       = phase_vld && (!onehot || (!match && (state_q == ACQ || state_q == LOCK)));
    wrap_d    = phase_vld && (state_q == LOCK) && match && phase_in[N-1];
    fault_set = phase_vld && (state_q == LOCK) && !match;
  end

  // Sample history, pulses and counters; clr discards the current sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      fault_q   <= 1'b0;
      err_q     <= '0;
      wrap_q    <= 1'b0;
      rev_q     <= '0;
    end else if (clr) begin
      prev_q    <= '0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      fault_q   <= 1'b0;
      err_q     <= '0;
      wrap_q    <= 1'b0;
      rev_q     <= '0;
    end else begin
      idx_vld_q <= accept;
      wrap_q    <= wrap_d;
      if (accept) begin
        prev_q <= phase_in;
        idx_q  <= pos;
      end
      if (bad && (err_q != '1)) begin
        err_q <= err_q + {{(ERR_W-1){1'b0}}, 1'b1};
      end
      if (wrap_d) begin
        rev_q <= rev_q + {{(REV_W-1){1'b0}}, 1'b1};
      end
      if (fault_set) begin
        fault_q <= 1'b1;
      end
    end
  end

`ifdef RING_PHASE_MON_SNAP_EN
  logic [N-1:0] snap_q;
  logic         snap_seen_q;

  // Capture only the first bad sample after reset or clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q      <= '0;
      snap_seen_q <= 1'b0;
    end else if (clr) begin
      snap_q      <= '0;
      snap_seen_q <= 1'b0;
    end else if (bad && !snap_seen_q) begin
      snap_q      <= phase_in;
      snap_seen_q <= 1'b1;
    end
  end

  assign last_bad = snap_q;
`endif

  assign idx        = idx_q;
  assign idx_vld    = idx_vld_q;
  assign locked     = (state_q == LOCK);
  assign fault      = fault_q;
  assign err_cnt    = err_q;
  assign wrap_pulse = wrap_q;
  assign rev_cnt    = rev_q;

endmodule

// File: tb/tb_ring_phase_monitor.sv
// tb_ring_phase_monitor: directed scenarios followed by random stimulus.
// Every output is compared against a behavioural model of the ring monitor.
// A second instance with ERR_W=2 exercises saturation of the error counter.
module tb_ring_phase_monitor;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int LOCK_CNT = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             phase_vld;
  logic [N-1:0]     phase_in;

  logic [IDX_W-1:0] idx, idx2;
  logic             idxVld, idxVld2;
  logic             locked, locked2;
  logic             fault, fault2;
  logic [7:0]       errCnt;
  logic [1:0]       errCnt2;
  logic             wrapPulse, wrapPulse2;
  logic [7:0]       revCnt, revCnt2;
`ifdef RING_PHASE_MON_SNAP_EN
  logic [N-1:0]     lastBad, lastBad2;
`endif

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  int mMode;
  int mGood;
  int mPrevIdx;
  int mIdx;
  int mIdxVld;
  int mLocked;
  int mFault;
  int mErr;
  int mErr2;
  int mWrap;
  int mRev;
  int mBadSeen;
  int mLastBad;

  ring_phase_monitor #(.N(N), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .ERR_W(8), .REV_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .phase_vld(phase_vld), .phase_in(phase_in),
    .idx(idx), .idx_vld(idxVld), .locked(locked), .fault(fault), .err_cnt(errCnt),
    .wrap_pulse(wrapPulse), .rev_cnt(revCnt)
`ifdef RING_PHASE_MON_SNAP_EN
    , .last_bad(lastBad)
`endif
  );

  ring_phase_monitor #(.N(N), .IDX_W(IDX_W), .LOCK_CNT(LOCK_CNT), .ERR_W(2), .REV_W(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .phase_vld(phase_vld), .phase_in(phase_in),
    .idx(idx2), .idx_vld(idxVld2), .locked(locked2), .fault(fault2), .err_cnt(errCnt2),
    .wrap_pulse(wrapPulse2), .rev_cnt(revCnt2)
`ifdef RING_PHASE_MON_SNAP_EN
    , .last_bad(lastBad2)
`endif
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    mMode = 0; mGood = 0; mPrevIdx = -1; mIdx = 0; mIdxVld = 0; mLocked = 0;
    mFault = 0; mErr = 0; mErr2 = 0; mWrap = 0; mRev = 0; mBadSeen = 0; mLastBad = 0;
  endtask

  // Model: mode 0 = waiting for an anchor, 1 = acquiring, 2 = locked
  task automatic modelStep(input logic v, input logic [N-1:0] p, input logic c);
    int  oh;
    int  pi;
    int  m;
    int  isBad;
    mIdxVld = 0;
    mWrap   = 0;
    if (c) begin
      modelReset();
      return;
    end
    if (!v) return;
    oh = ($countones(p) == 1);
    pi = 0;
    for (int i = 0; i < N; i++) if (p[i]) pi = i;
    m = oh && (mPrevIdx >= 0) && (pi == (mPrevIdx + N - 1) % N);
    isBad = 0;
    case (mMode)
      0: begin
        if (oh) begin mMode = 1; mGood = 0; end
        else isBad = 1;
      end
      1: begin
        if (m) begin
          mGood++;
          if (mGood == LOCK_CNT) mMode = 2;
        end else if (oh) begin
          isBad = 1; mGood = 0;
        end else begin
          isBad = 1; mMode = 0;
        end
      end
      default: begin
        if (m) begin
          if (p[N-1]) begin mWrap = 1; mRev = (mRev + 1) % 256; end
        end else begin
          isBad = 1; mFault = 1; mMode = 0;
        end
      end
    endcase
    if (isBad) begin
      if (mErr < 255) mErr++;
      if (mErr2 < 3) mErr2++;
      if (!mBadSeen) begin mBadSeen = 1; mLastBad = p; end
    end
    if (oh) begin
      mPrevIdx = pi; mIdx = pi; mIdxVld = 1;
    end
    mLocked = (mMode == 2);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".idx"}, 32'(idx), mIdx);
    checkOutput({tag, ".idx_vld"}, 32'(idxVld), mIdxVld);
    checkOutput({tag, ".locked"}, 32'(locked), mLocked);
    checkOutput({tag, ".fault"}, 32'(fault), mFault);
    checkOutput({tag, ".err_cnt"}, 32'(errCnt), mErr);
    checkOutput({tag, ".wrap_pulse"}, 32'(wrapPulse), mWrap);
    checkOutput({tag, ".rev_cnt"}, 32'(revCnt), mRev);
    checkOutput({tag, ".err_cnt2"}, 32'(errCnt2), mErr2);
    checkOutput({tag, ".locked2"}, 32'(locked2), mLocked);
    checkOutput({tag, ".idx2"}, {30'b0, idx2, 1'b0} | 32'(idxVld2) | {24'b0, revCnt2, 4'b0},
                (mIdx << 1) | mIdxVld | (mRev << 4));
    checkOutput({tag, ".flags2"}, {30'b0, fault2, wrapPulse2}, (mFault << 1) | mWrap);
`ifdef RING_PHASE_MON_SNAP_EN
    checkOutput({tag, ".last_bad"}, 32'(lastBad), mLastBad);
    checkOutput({tag, ".last_bad2"}, 32'(lastBad2), mLastBad);
`endif
  endtask

  // Drive one cycle of inputs, let the edge pass, then compare against the model
  task automatic applyStimulus(input string tag, input logic v, input logic [N-1:0] p,
                               input logic c);
    phase_vld = v;
    phase_in  = p;
    clr       = c;
    @(posedge clk);
    #1;
    modelStep(v, p, c);
    checkAll(tag);
  endtask

  initial begin
    logic [N-1:0] rv;
    int           cur;
    int           r;

    rst_n = 1'b0; clr = 1'b0; phase_vld = 1'b0; phase_in = '0;
    modelReset();
    #1;
    checkAll("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Scenario 1: acquire lock from an MSB-hot anchor
    applyStimulus("s1.1000", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s1.0100", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s1.0010", 1'b1, 4'b0010, 1'b0);
    applyStimulus("s1.0001", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s1.1000b", 1'b1, 4'b1000, 1'b0);
    checkOutput("s1.locked_const", 32'(locked), 32'd1);
    checkOutput("s1.wrap_const", 32'(wrapPulse), 32'd0);

    // Scenario 2: three revolutions while locked
    for (int rep = 0; rep < 3; rep++) begin
      applyStimulus("s2.0100", 1'b1, 4'b0100, 1'b0);
      applyStimulus("s2.0010", 1'b1, 4'b0010, 1'b0);
      applyStimulus("s2.0001", 1'b1, 4'b0001, 1'b0);
      applyStimulus("s2.1000", 1'b1, 4'b1000, 1'b0);
    end
    checkOutput("s2.rev_const", 32'(revCnt), 32'd3);

    // Scenario 3: corrupt sample while locked, then re-lock
    applyStimulus("s3.0110", 1'b1, 4'b0110, 1'b0);
    checkOutput("s3.fault_const", 32'(fault), 32'd1);
    checkOutput("s3.err_const", 32'(errCnt), 32'd1);
`ifdef RING_PHASE_MON_SNAP_EN
    checkOutput("s3.last_bad_const", 32'(lastBad), 32'h6);
`endif
    applyStimulus("s3.0100", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s3.0010", 1'b1, 4'b0010, 1'b0);
    applyStimulus("s3.0001", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s3.1000", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s3.0100b", 1'b1, 4'b0100, 1'b0);
    checkOutput("s3.relock_const", 32'(locked), 32'd1);

    // Scenario 4: skipped phase during acquisition re-anchors
    applyStimulus("s4.clr", 1'b0, 4'b0000, 1'b1);
    applyStimulus("s4.1000", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s4.0010", 1'b1, 4'b0010, 1'b0);
    checkOutput("s4.err_const", 32'(errCnt), 32'd1);
    applyStimulus("s4.0001", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s4.1000b", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s4.0100", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s4.0010b", 1'b1, 4'b0010, 1'b0);
    checkOutput("s4.locked_const", 32'(locked), 32'd1);

    // Scenario 5: zero samples saturate the narrow error counter
    applyStimulus("s5.clr", 1'b0, 4'b0000, 1'b1);
    for (int k = 0; k < 5; k++) applyStimulus("s5.0000", 1'b1, 4'b0000, 1'b0);
    checkOutput("s5.err2_const", 32'(errCnt2), 32'd3);

    // Scenario 6: clr beats a valid sample, then asynchronous reset while locked
    applyStimulus("s6.1000", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s6.0100", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s6.0010", 1'b1, 4'b0010, 1'b0);
    applyStimulus("s6.0001", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s6.1000b", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s6.clr_vld", 1'b1, 4'b0100, 1'b1);
    checkOutput("s6.clr_idx_vld_const", 32'(idxVld), 32'd0);
    applyStimulus("s6.0000", 1'b1, 4'b0000, 1'b0);
    applyStimulus("s6.r1000", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s6.r0100", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s6.r0010", 1'b1, 4'b0010, 1'b0);
    applyStimulus("s6.r0001", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s6.r1000b", 1'b1, 4'b1000, 1'b0);
    applyStimulus("s6.r0100b", 1'b1, 4'b0100, 1'b0);
    applyStimulus("s6.r0010b", 1'b1, 4'b0010, 1'b0);
    applyStimulus("s6.r0001b", 1'b1, 4'b0001, 1'b0);
    applyStimulus("s6.r1000c", 1'b1, 4'b1000, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("s6.async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus("s6.after_reset", 1'b1, 4'b0100, 1'b0);

    // Random stimulus: mostly clean rotations with occasional corruption
    cur = 3;
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      begin cur = (cur + N - 1) % N; rv = 4'b0001 << cur; end
      else if (r < 80) begin cur = int'($urandom_range(0, N - 1)); rv = 4'b0001 << cur; end
      else if (r < 90) rv = 4'(($urandom_range(0, 15)));
      else             rv = 4'b0001 << cur;
      applyStimulus("rand", ($urandom_range(0, 3) != 0), rv, ($urandom_range(0, 49) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
